// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/response port
//
// Purpose: groups the fetch unit's req/gnt/rvalid memory port.
// Signals:
//   req     fetch request valid (master -> slave)
//   addr    word-aligned fetch address (master -> slave)
//   gnt     request accepted this cycle (slave -> master)
//   rvalid  response data valid, returned in request order (slave -> master)
//   rdata   instruction word (slave -> master)
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
//
// Purpose: issues sequential word fetches under a credit limit, tags each
// request with its PC, buffers returned {PC, instruction} pairs and presents
// the oldest one to IF/ID. Redirects flush everything and refetch from the
// target; stalls hold the presented entry while fetching continues.
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous, active-low reset
//   stall        IF/ID not accepting; hold the head entry
//   redirect     branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc  target PC (bits [1:0] ignored)
//   imem         memory port (master side): req/addr/gnt/rvalid/rdata
//   valid_o      PC_o/Instr_o hold a real instruction
//   PC_o         PC of the presented instruction (0 when invalid)
//   Instr_o      presented instruction (NOP 0x13 when invalid)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic                   valid_o,
  output logic [31:0]            PC_o,
  output logic [31:0]            Instr_o
);

  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam int SLOTS = 1 << PW;
  localparam logic [CW:0]  DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [31:0]  NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] buf_cnt;

  // PC tag queue: one entry per live (non-discarded) outstanding request
  logic [31:0]   tag_mem [SLOTS];
  logic [PW-1:0] tag_wp, tag_rp;

  // Fetch buffer of {PC, instruction}
  logic [31:0]   buf_pc    [SLOTS];
  logic [31:0]   buf_instr [SLOTS];
  logic [PW-1:0] buf_wp, buf_rp;

  logic [CW:0]   in_flight;
  logic          credit_ok;
  logic          issue;
  logic          resp_keep;
  logic          pop;
  logic [31:0]   target_pc;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // Credits cover both buffered entries and outstanding requests, including
  // ones already marked for discard, so the buffer can never overflow.
  assign in_flight = {1'b0, outstanding} + {1'b0, buf_cnt};
  assign credit_ok = in_flight < DEPTH_W;

  assign imem.req  = RESET & ~redirect & credit_ok;
  assign imem.addr = fetch_pc;

  assign issue     = imem.req & imem.gnt;
  assign resp_keep = imem.rvalid & ~redirect & (discard == '0);
  assign pop       = (buf_cnt != '0) & ~stall & ~redirect;

  assign valid_o = (buf_cnt != '0);
  assign PC_o    = valid_o ? buf_pc[buf_rp]    : 32'h0;
  assign Instr_o = valid_o ? buf_instr[buf_rp] : NOP;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      tag_wp      <= '0;
      tag_rp      <= '0;
      buf_wp      <= '0;
      buf_rp      <= '0;
      buf_cnt     <= '0;
    end else begin
      case ({issue, imem.rvalid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (redirect) begin
        // Everything still in flight (minus a response landing now) is stale.
        fetch_pc <= target_pc;
        discard  <= outstanding - CW'(imem.rvalid);
        tag_rp   <= tag_wp;
        buf_rp   <= buf_wp;
        buf_cnt  <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wp   <= nxt(tag_wp);
        end
        // Stale responses never had a live tag, so they do not pop one.
        if (imem.rvalid) begin
          if (discard != '0) discard <= discard - 1'b1;
          else               tag_rp  <= nxt(tag_rp);
        end
        if (resp_keep) buf_wp <= nxt(buf_wp);
        if (pop)       buf_rp <= nxt(buf_rp);
        case ({resp_keep, pop})
          2'b10:   buf_cnt <= buf_cnt + 1'b1;
          2'b01:   buf_cnt <= buf_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) tag_mem[tag_wp] <= fetch_pc;
    if (resp_keep) begin
      buf_pc[buf_wp]    <= tag_mem[tag_rp];
      buf_instr[buf_wp] <= imem.rdata;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge CLK) disable iff (!RESET)
    imem.rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  localparam int          BD  = 3;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid_o;
  logic [31:0] PC_o, Instr_o;

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(BD)) dut (
    .CLK(CLK), .RESET(RESET), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem),
    .valid_o(valid_o), .PC_o(PC_o), .Instr_o(Instr_o)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] pc; bit dead; } ostd_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] a; int due; } pend_t;

  ostd_t oq[$];
  ent_t  bq[$];
  pend_t pending[$];
  logic [31:0] m_pc = RPC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    oq.delete();
    bq.delete();
    pending.delete();
    m_pc = RPC;
  endtask

  task automatic tick();
    logic        e_req, e_valid;
    logic [31:0] e_pc, e_ins;
    ostd_t       r;
    @(negedge CLK);
    e_req   = RESET && !redirect && (oq.size() + bq.size() < BD);
    e_valid = RESET && (bq.size() > 0);
    e_pc    = e_valid ? bq[0].pc  : 32'h0;
    e_ins   = e_valid ? bq[0].ins : NOP;
    s_req = imem.req; s_addr = imem.addr; s_valid = valid_o; s_pc = PC_o; s_instr = Instr_o;
    chk("req", {31'b0, s_req}, {31'b0, e_req});
    if (e_req) chk("addr", s_addr, m_pc);
    chk("valid", {31'b0, s_valid}, {31'b0, e_valid});
    chk("pc", s_pc, e_pc);
    chk("instr", s_instr, e_ins);
    if (imem.req === 1'b1 && imem.gnt === 1'b1) pending.push_back('{imem.addr, cyc + lat});
    if (!RESET) begin
      model_reset();
    end else begin
      if (bq.size() > 0 && !stall && !redirect) void'(bq.pop_front());
      if (imem.rvalid) begin
        if (oq.size() == 0) chk("rvalid_orphan", 32'd1, 32'd0);
        else begin
          r = oq.pop_front();
          if (!r.dead && !redirect) bq.push_back('{r.pc, mem_f(r.pc)});
        end
      end
      if (redirect) begin
        foreach (oq[i]) oq[i].dead = 1'b1;
        bq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (e_req && imem.gnt) begin
        oq.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (RESET && pending.size() > 0 && pending[0].due <= cyc) begin
      imem.rvalid = 1'b1;
      imem.rdata  = mem_f(pending[0].a);
      void'(pending.pop_front());
    end else begin
      imem.rvalid = 1'b0;
      imem.rdata  = 32'h0;
    end
  endtask

  task automatic wait_valid_pc(input string nm, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (s_valid) begin found = 1'b1; break; end
      tick();
    end
    chk({nm, "_wait"}, {31'b0, found}, 32'd1);
    if (found) chk({nm, "_pc"}, s_pc, exp_pc);
  endtask

  initial begin
    logic [31:0] held_pc, held_ins;
    int nv;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;

    // Reset state
    tick();
    chk("rst_req", {31'b0, s_req}, 32'd0);
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_instr", s_instr, NOP);
    tick();

    // T2 streaming
    RESET = 1'b1; imem.gnt = 1'b1; lat = 1; nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) chk("t1_first_addr", s_addr, RPC);
      if (s_valid) begin
        chk("t2_pc", s_pc, 32'(4 * nv));
        chk("t2_instr", s_instr, 32'(4 * nv) ^ 32'h5A5A_F00D);
        nv++;
      end
    end
    chk("t2_count", 32'(nv), 32'd10);

    // T3 stall
    stall = 1'b1;
    tick();
    held_pc = s_pc; held_ins = s_instr;
    chk("t3_pc", s_pc, 32'h28);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_pc", s_pc, held_pc);
      chk("t3_hold_instr", s_instr, held_ins);
    end
    chk("t3_req_blocked", {31'b0, s_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("t3_release_pc", s_pc, 32'h28);
    tick();
    chk("t3_next_pc", s_pc, 32'h2C);

    // T4 redirect with requests outstanding
    lat = 3;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    chk("t4_req_redirect", {31'b0, s_req}, 32'd0);
    redirect = 1'b0;
    tick();
    chk("t4_addr", s_addr, 32'h100);
    chk("t4_req", {31'b0, s_req}, 32'd1);
    wait_valid_pc("t4", 32'h100);

    // T5 redirect + stall + rvalid in one cycle
    lat = 1;
    for (int i = 0; i < 6; i++) tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    stall = 1'b0; redirect = 1'b0;
    tick();
    chk("t5_valid", {31'b0, s_valid}, 32'd0);
    wait_valid_pc("t5", 32'h200);

    // T6 backpressure at the top of the address space
    imem.gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_req", {31'b0, s_req}, 32'd1);
      chk("t6_addr_held", s_addr, 32'hFFFF_FFFC);
    end
    imem.gnt = 1'b1;
    tick();
    tick();
    chk("t6_wrap_addr", s_addr, 32'h0);
    wait_valid_pc("t6", 32'hFFFF_FFFC);

    // T1 reset mid-fetch
    lat = 4;
    for (int i = 0; i < 4; i++) tick();
    RESET = 1'b0;
    imem.rvalid = 1'b0; imem.rdata = 32'h0;
    model_reset();
    tick();
    chk("t1_req", {31'b0, s_req}, 32'd0);
    chk("t1_valid", {31'b0, s_valid}, 32'd0);
    chk("t1_instr", s_instr, NOP);
    tick();
    RESET = 1'b1; lat = 1;
    tick();
    chk("t1_restart_addr", s_addr, RPC);
    chk("t1_restart_req", {31'b0, s_req}, 32'd1);
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
